score_display_ctrl: RTL and testbench

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

---
 rtl/score_display_ctrl.sv | 153 +++++++++++++++
 tb/tb_score_display_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_ctrl.sv
// Score display controller: binary score to three BCD digits
// via serial double-dabble, with leading-zero blanking and range flag.
module score_display_ctrl #(
  parameter int MAX_SCORE = 300,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       score_valid,
  input  logic [8:0] score,
  output logic       score_ready,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       disp_update,
  output logic       range_err
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    UPDATE
  } state_e;

  localparam logic [9:0] MAX_LIM = 10'(MAX_SCORE);
  localparam logic [3:0] BLANK   = 4'hF;
  localparam logic [3:0] RST_H   = BLANK_LZ ? BLANK : 4'h0;
  localparam logic [3:0] RST_T   = BLANK_LZ ? BLANK : 4'h0;
  localparam logic [3:0] RST_O   = 4'h0;
  localparam logic [3:0] LAST    = 4'd8;

  state_e      state_q, state_d;
  logic [8:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        upd_q, upd_d;
  logic        rerr_q, rerr_d;

  logic [11:0] bcd_adj;
  logic [11:0] bcd_sh;
  logic [8:0]  bin_sh;
  logic        in_range;
  logic        h_blank;
  logic        t_blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble step and the blanking decode of the result
  always_comb begin
    bcd_adj  = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    bcd_sh   = {bcd_adj[10:0], bin_q[8]};
    bin_sh   = {bin_q[7:0], 1'b0};
    in_range = ({1'b0, score} <= MAX_LIM);
    h_blank  = BLANK_LZ && (bcd_q[11:8] == 4'd0);
    t_blank  = h_blank && (bcd_q[7:4] == 4'd0);
  end

  // Next-state and datapath update for the conversion sequence
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    rerr_d  = rerr_q;
    upd_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (score_valid) begin
          bin_d = score;
          bcd_d = '0;
          cnt_d = '0;
          if (in_range) begin
            rerr_d  = 1'b0;
            state_d = CONV;
          end else begin
            rerr_d  = 1'b1;
            state_d = UPDATE;
          end
        end
      end
      CONV: begin
        bcd_d = bcd_sh;
        bin_d = bin_sh;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (rerr_q) begin
          hund_d = BLANK;
          tens_d = BLANK;
          ones_d = BLANK;
        end else begin
          hund_d = h_blank ? BLANK : bcd_q[11:8];
          tens_d = t_blank ? BLANK : bcd_q[7:4];
          ones_d = bcd_q[3:0];
        end
        upd_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hund_q  <= RST_H;
      tens_q  <= RST_T;
      ones_q  <= RST_O;
      upd_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      upd_q   <= upd_d;
      rerr_q  <= rerr_d;
    end
  end

  // Handshake and status decoded straight from state
  always_comb begin
    score_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
    hundreds    = hund_q;
    tens        = tens_q;
    ones        = ones_q;
    disp_update = upd_q;
    range_err   = rerr_q;
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: vector table plus scoreboard
// keyed on disp_update, with hand sequences for corner cases.
module tb_score_display_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic [8:0] score_a = '0, score_b = '0;
  logic       ready_a, ready_b;
  logic [3:0] h_a, t_a, o_a, h_b, t_b, o_b;
  logic       busy_a, busy_b, upd_a, upd_b, re_a, re_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit         b;
    logic [8:0] s;
    logic [3:0] h, t, o;
    logic       re;
  } vec_t;

  typedef struct {
    logic [3:0] h, t, o;
    logic       re;
    int         due;
  } sb_t;

  sb_t  qa[$];
  sb_t  qb[$];
  vec_t vecs[$];

  score_display_ctrl u_a (
    .clk(clk), .rst(rst),
    .score_valid(valid_a), .score(score_a),
    .score_ready(ready_a),
    .hundreds(h_a), .tens(t_a), .ones(o_a),
    .busy(busy_a), .disp_update(upd_a),
    .range_err(re_a)
  );

  score_display_ctrl #(
    .MAX_SCORE(511), .BLANK_LZ(1'b0)
  ) u_b (
    .clk(clk), .rst(rst),
    .score_valid(valid_b), .score(score_b),
    .score_ready(ready_b),
    .hundreds(h_b), .tens(t_b), .ones(o_b),
    .busy(busy_b), .disp_update(upd_b),
    .range_err(re_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input bit b);
    sb_t e;
    logic       u, r, re;
    logic [3:0] h, t, o;
    u  = b ? upd_b : upd_a;
    r  = b ? ready_b : ready_a;
    re = b ? re_b : re_a;
    h  = b ? h_b : h_a;
    t  = b ? t_b : t_a;
    o  = b ? o_b : o_a;
    if (!u) return;
    if ((b ? qb.size() : qa.size()) == 0) begin
      chk(b ? "b_unexpected_pulse" : "a_unexpected_pulse",
          32'(u), 32'(0));
      return;
    end
    e = b ? qb.pop_front() : qa.pop_front();
    chk(b ? "b_digits" : "a_digits",
        {20'd0, h, t, o}, {20'd0, e.h, e.t, e.o});
    chk(b ? "b_range_err" : "a_range_err",
        32'(re), 32'(e.re));
    chk(b ? "b_ready_on_pulse" : "a_ready_on_pulse",
        32'(r), 32'(1));
    chk(b ? "b_latency" : "a_latency", 32'(cyc), 32'(e.due));
  endtask

  // Scoreboard consumer: compare on every display pulse
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      mon(1'b0);
      mon(1'b1);
    end
  end

  task automatic send(input bit b, input logic [8:0] s,
                      input logic [3:0] h, input logic [3:0] t,
                      input logic [3:0] o, input logic re,
                      input bit keep);
    bit  rdy;
    bit  ok;
    sb_t e;
    int  mx;
    ok = 1'b0;
    if (b) begin valid_b = 1'b1; score_b = s; end
    else begin valid_a = 1'b1; score_a = s; end
    for (int n = 0; n < 60 && !ok; n++) begin
      rdy = b ? ready_b : ready_a;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
    end
    if (!ok) begin
      chk("accept_timeout", 32'(0), 32'(1));
    end else begin
      mx    = b ? 511 : 300;
      e.h   = h;
      e.t   = t;
      e.o   = o;
      e.re  = re;
      e.due = cyc + ((int'(s) > mx) ? 1 : 10);
      if (b) qb.push_back(e);
      else qa.push_back(e);
      chk(b ? "b_range_err_at_accept" : "a_range_err_at_accept",
          32'(b ? re_b : re_a), 32'(re));
    end
    if (!keep) begin
      if (b) valid_b = 1'b0;
      else valid_a = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 80 && (qa.size() + qb.size()) > 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", 32'(qa.size() + qb.size()), 32'(0));
  endtask

  initial begin
    vecs.push_back('{0, 9'd300, 4'h3, 4'h0, 4'h0, 1'b0});
    vecs.push_back('{0, 9'd107, 4'h1, 4'h0, 4'h7, 1'b0});
    vecs.push_back('{0, 9'd45,  4'hF, 4'h4, 4'h5, 1'b0});
    vecs.push_back('{0, 9'd301, 4'hF, 4'hF, 4'hF, 1'b1});
    vecs.push_back('{0, 9'd9,   4'hF, 4'hF, 4'h9, 1'b0});
    vecs.push_back('{0, 9'd100, 4'h1, 4'h0, 4'h0, 1'b0});
    vecs.push_back('{0, 9'd10,  4'hF, 4'h1, 4'h0, 1'b0});
    vecs.push_back('{0, 9'd299, 4'h2, 4'h9, 4'h9, 1'b0});
    vecs.push_back('{0, 9'd511, 4'hF, 4'hF, 4'hF, 1'b1});
    vecs.push_back('{0, 9'd5,   4'hF, 4'hF, 4'h5, 1'b0});
    vecs.push_back('{1, 9'd7,   4'h0, 4'h0, 4'h7, 1'b0});
    vecs.push_back('{1, 9'd511, 4'h5, 4'h1, 4'h1, 1'b0});
    vecs.push_back('{1, 9'd0,   4'h0, 4'h0, 4'h0, 1'b0});
    vecs.push_back('{1, 9'd99,  4'h0, 4'h9, 4'h9, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", 32'({ready_a, ready_b}), 32'(3));
    chk("rst_busy", 32'({busy_a, busy_b}), 32'(0));
    chk("rst_upd", 32'({upd_a, upd_b}), 32'(0));
    chk("rst_rerr", 32'({re_a, re_b}), 32'(0));
    chk("rst_digits_a", 32'({h_a, t_a, o_a}), 32'(12'hFF0));
    chk("rst_digits_b", 32'({h_b, t_b, o_b}), 32'(12'h000));

    // score 0: busy for exactly 10 cycles, then one pulse
    send(0, 9'd0, 4'hF, 4'hF, 4'h0, 1'b0, 0);
    chk("zero_busy_0", 32'(busy_a), 32'(1));
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("zero_busy", 32'(busy_a), 32'(1));
    end
    @(posedge clk);
    #1;
    chk("zero_busy_end", 32'(busy_a), 32'(0));
    chk("zero_pulse", 32'(upd_a), 32'(1));
    @(posedge clk);
    #1;
    chk("zero_pulse_end", 32'(upd_a), 32'(0));

    // table: back-to-back sends, scoreboard checks each display
    foreach (vecs[i]) begin
      send(vecs[i].b, vecs[i].s, vecs[i].h, vecs[i].t,
           vecs[i].o, vecs[i].re, 0);
    end
    drain();

    // valid held through busy while score changes 250 -> 99
    send(0, 9'd250, 4'h2, 4'h5, 4'h0, 1'b0, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    score_a = 9'd99;
    send(0, 9'd99, 4'hF, 4'h9, 4'h9, 1'b0, 0);
    drain();
    chk("hold_digits", 32'({h_a, t_a, o_a}), 32'(12'hF99));

    // reset on the 5th conversion edge of 123 aborts it
    send(0, 9'd123, 4'h1, 4'h2, 4'h3, 1'b0, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete();
    chk("abort_digits", 32'({h_a, t_a, o_a}), 32'(12'hFF0));
    chk("abort_upd", 32'(upd_a), 32'(0));
    chk("abort_ready", 32'(ready_a), 32'(1));
    chk("abort_busy", 32'(busy_a), 32'(0));
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    chk("abort_digits_hold", 32'({h_a, t_a, o_a}), 32'(12'hFF0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
